// File: rtl/next_piece_spawner_pkg.sv
// Shared constants and FSM encoding for the next-piece spawner.
package next_piece_spawner_pkg;
  localparam logic [7:0] NEXT_BASE     = 8'd232;
  localparam int         PREVIEW_CELLS = 12;
  localparam logic [7:0] PREVIEW_COLS  = 8'd3;
  localparam logic [7:0] FIELD_COLS    = 8'd10;
  localparam logic [7:0] SPAWN_BASE    = 8'd4;
  localparam logic [7:0] EMPTY_CELL    = 8'd0;

  localparam logic [3:0] READ_LAST  = 4'd12;
  localparam logic [3:0] CHECK_LAST = 4'd4;
  localparam logic [3:0] WRITE_LAST = 4'd3;
  localparam logic [3:0] PIECE_SIZE = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/next_piece_spawner_if.sv
// Grid memory port: registered read (data one cycle after address), write strobe.
interface next_piece_spawner_if;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/next_piece_spawner_spawn_addr_map.sv
// Maps a preview index (row-major, 3 wide) onto its spawn address in the playfield.
module spawn_addr_map
  import next_piece_spawner_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] addr
);
  logic [7:0] idx_w;
  logic [7:0] row;
  logic [7:0] col;

  always_comb begin
    idx_w = {4'b0000, idx};
    row   = idx_w / PREVIEW_COLS;
    col   = idx_w % PREVIEW_COLS;
    addr  = SPAWN_BASE + row * FIELD_COLS + col;
  end
endmodule

// File: rtl/next_piece_spawner.sv
// Copies the 3x4 preview piece into the top of the playfield, or flags game over on collision.
//   state    | meaning
//   ST_IDLE  | waiting for start, bus quiet
//   ST_READ  | stream 12 preview cells in, collect occupied addresses (13 cycles)
//   ST_CHECK | read the 4 target cells, OR their occupancy (5 cycles)
//   ST_WRITE | write piece_code to the 4 targets (4 cycles)
//   ST_DONE  | done pulse, back to idle
module next_piece_spawner
  import next_piece_spawner_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        game_over,
  output logic                        bad_piece,
  next_piece_spawner_if.master        mem,
  output logic [7:0]                  cell_addr_0,
  output logic [7:0]                  cell_addr_1,
  output logic [7:0]                  cell_addr_2,
  output logic [7:0]                  cell_addr_3,
  output logic [7:0]                  piece_code
);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] occ_q, occ_d;
  logic       hit_q, hit_d;
  logic       game_over_q, game_over_d;
  logic       bad_piece_q, bad_piece_d;
  logic [7:0] piece_code_q, piece_code_d;
  logic [7:0] cell_addr_q [4];
  logic [7:0] cell_addr_d [4];
  logic [7:0] pbuf_q [PREVIEW_CELLS];
  logic [7:0] pbuf_d [PREVIEW_CELLS];

  logic [3:0] map_idx;
  logic [7:0] map_addr;
  logic [7:0] mem_addr_c;
  logic       mem_we_c;
  logic [7:0] mem_wdata_c;

  // Data for preview cell k arrives while cnt_q == k+1, so the mapper follows cnt_q-1.
  assign map_idx = cnt_q - 4'd1;

  spawn_addr_map u_addr_map (
    .idx  (map_idx),
    .addr (map_addr)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    occ_d        = occ_q;
    hit_d        = hit_q;
    game_over_d  = game_over_q;
    bad_piece_d  = bad_piece_q;
    piece_code_d = piece_code_q;
    cell_addr_d  = cell_addr_q;
    pbuf_d       = pbuf_q;
    mem_addr_c   = 8'd0;
    mem_we_c     = 1'b0;
    mem_wdata_c  = 8'd0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          cnt_d   = 4'd0;
          occ_d   = 4'd0;
          hit_d   = 1'b0;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (cnt_q < READ_LAST) mem_addr_c = NEXT_BASE + {4'b0000, cnt_q};
        if (cnt_q != 4'd0) begin
          pbuf_d[map_idx] = mem.mem_rdata;
          if (mem.mem_rdata != EMPTY_CELL) begin
            occ_d = occ_q + 4'd1;
            if (occ_q < PIECE_SIZE) cell_addr_d[occ_q[1:0]] = map_addr;
          end
        end
        if (cnt_q == READ_LAST) begin
          cnt_d = 4'd0;
          // Lowest occupied preview entry defines the piece colour.
          for (int i = PREVIEW_CELLS - 1; i >= 0; i--) begin
            if (pbuf_d[i] != EMPTY_CELL) piece_code_d = pbuf_d[i];
          end
          if (occ_d == PIECE_SIZE) begin
            state_d = ST_CHECK;
          end else begin
            bad_piece_d = 1'b1;
            state_d     = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (cnt_q < CHECK_LAST) mem_addr_c = cell_addr_q[cnt_q[1:0]];
        if (cnt_q != 4'd0 && mem.mem_rdata != EMPTY_CELL) hit_d = 1'b1;
        if (cnt_q == CHECK_LAST) begin
          cnt_d = 4'd0;
          if (hit_d) begin
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WRITE: begin
        busy        = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = cell_addr_q[cnt_q[1:0]];
        mem_wdata_c = piece_code_q;
        if (cnt_q == WRITE_LAST) begin
          cnt_d   = 4'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      occ_q        <= 4'd0;
      hit_q        <= 1'b0;
      game_over_q  <= 1'b0;
      bad_piece_q  <= 1'b0;
      piece_code_q <= 8'd0;
      for (int i = 0; i < 4; i++) cell_addr_q[i] <= 8'd0;
      for (int i = 0; i < PREVIEW_CELLS; i++) pbuf_q[i] <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      occ_q        <= occ_d;
      hit_q        <= hit_d;
      game_over_q  <= game_over_d;
      bad_piece_q  <= bad_piece_d;
      piece_code_q <= piece_code_d;
      cell_addr_q  <= cell_addr_d;
      pbuf_q       <= pbuf_d;
    end
  end

  assign mem.mem_addr  = mem_addr_c;
  assign mem.mem_we    = mem_we_c;
  assign mem.mem_wdata = mem_wdata_c;
  assign game_over     = game_over_q;
  assign bad_piece     = bad_piece_q;
  assign piece_code    = piece_code_q;
  assign cell_addr_0   = cell_addr_q[0];
  assign cell_addr_1   = cell_addr_q[1];
  assign cell_addr_2   = cell_addr_q[2];
  assign cell_addr_3   = cell_addr_q[3];
endmodule

// File: tb/tb_next_piece_spawner.sv
// Directed bench: grid memory model with registered read, hand-computed spawn results.
module tb_next_piece_spawner;
  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, game_over, bad_piece;
  logic [7:0] cell_addr_0, cell_addr_1, cell_addr_2, cell_addr_3, piece_code;

  next_piece_spawner_if bus ();

  next_piece_spawner dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .game_over   (game_over),
    .bad_piece   (bad_piece),
    .mem         (bus),
    .cell_addr_0 (cell_addr_0),
    .cell_addr_1 (cell_addr_1),
    .cell_addr_2 (cell_addr_2),
    .cell_addr_3 (cell_addr_3),
    .piece_code  (piece_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // grid memory model; bench preloads through clr/ld while the DUT is idle
  logic [7:0] gmem [256];
  logic [7:0] rd_q;
  logic       clr, ld_en;
  logic [7:0] ld_a, ld_d;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) gmem[i] <= 8'd0;
    end else if (ld_en) begin
      gmem[ld_a] <= ld_d;
    end else if (bus.mem_we) begin
      gmem[bus.mem_addr] <= bus.mem_wdata;
    end
    rd_q <= gmem[bus.mem_addr];
  end
  assign bus.mem_rdata = rd_q;

  int n_checks, n_errors;
  int we_cnt, done_cnt, done_cyc, fld_rd;
  logic [7:0] wa [8];
  logic [7:0] wd [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic load_piece(input logic [11:0] mask, input logic [7:0] code);
    for (int k = 0; k < 12; k++) begin
      if (mask[k]) poke(8'(232 + k), code);
    end
  endtask

  task automatic observe(input int cyc);
    if (done) begin
      done_cnt++;
      if (done_cyc == 0) done_cyc = cyc;
    end
    if (bus.mem_we) begin
      if (we_cnt < 8) begin
        wa[we_cnt] = bus.mem_addr;
        wd[we_cnt] = bus.mem_wdata;
      end
      we_cnt++;
    end else if (busy && bus.mem_addr >= 8'd1 && bus.mem_addr < 8'd232) begin
      fld_rd++;
    end
  endtask

  // cycle 1 is the cycle right after the start-accept edge; runs a fixed 40 cycles
  task automatic run_spawn(input bit repulse);
    we_cnt = 0; done_cnt = 0; done_cyc = 0; fld_rd = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      observe(cyc);
      start = repulse && (cyc == 5 || cyc == 16 || cyc == 20);
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b0; start = 1'b0; clr = 1'b0; ld_en = 1'b0; ld_a = 8'd0; ld_d = 8'd0;
    we_cnt = 0; done_cnt = 0; done_cyc = 0; fld_rd = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_bad_piece", bad_piece, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_cell_addr_0", cell_addr_0, 0);
    chk("rst_piece_code", piece_code, 0);
    rst = 1'b1;
    clear_mem();

    // I piece: preview 0,3,6,9 -> field 4,14,24,34
    load_piece(12'b0010_0100_1001, 8'd1);
    run_spawn(1'b0);
    chk("i_done_cyc", done_cyc, 23);
    chk("i_done_cnt", done_cnt, 1);
    chk("i_we_cnt", we_cnt, 4);
    chk("i_wa0", wa[0], 4);
    chk("i_wa1", wa[1], 14);
    chk("i_wa2", wa[2], 24);
    chk("i_wa3", wa[3], 34);
    chk("i_wd0", wd[0], 1);
    chk("i_wd3", wd[3], 1);
    chk("i_cell0", cell_addr_0, 4);
    chk("i_cell1", cell_addr_1, 14);
    chk("i_cell2", cell_addr_2, 24);
    chk("i_cell3", cell_addr_3, 34);
    chk("i_piece_code", piece_code, 1);
    chk("i_game_over", game_over, 0);
    chk("i_bad_piece", bad_piece, 0);

    // O piece: preview 6,7,9,10 -> field 24,25,34,35
    clear_mem();
    load_piece(12'b0110_1100_0000, 8'd2);
    run_spawn(1'b0);
    chk("o_done_cyc", done_cyc, 23);
    chk("o_done_cnt", done_cnt, 1);
    chk("o_busy_after", busy, 0);
    chk("o_we_cnt", we_cnt, 4);
    chk("o_wa0", wa[0], 24);
    chk("o_wa1", wa[1], 25);
    chk("o_wa2", wa[2], 34);
    chk("o_wa3", wa[3], 35);
    chk("o_wd1", wd[1], 2);
    chk("o_piece_code", piece_code, 2);
    chk("o_cell3", cell_addr_3, 35);

    // collision on field[14]
    clear_mem();
    load_piece(12'b0010_0100_1001, 8'd1);
    poke(8'd14, 8'd3);
    run_spawn(1'b0);
    chk("col_done_cyc", done_cyc, 19);
    chk("col_game_over", game_over, 1);
    chk("col_we_cnt", we_cnt, 0);
    chk("col_fld_rd", fld_rd, 4);
    chk("col_cell1_hold", cell_addr_1, 14);
    chk("col_piece_code", piece_code, 1);

    // bad preview: only 3 cells
    clear_mem();
    load_piece(12'b0000_0100_1001, 8'd5);
    run_spawn(1'b0);
    chk("bad_done_cyc", done_cyc, 14);
    chk("bad_flag", bad_piece, 1);
    chk("bad_we_cnt", we_cnt, 0);
    chk("bad_fld_rd", fld_rd, 0);
    chk("bad_game_over_sticky", game_over, 1);

    // reset during WRITE, while the third write is on the bus
    clear_mem();
    load_piece(12'b0010_0100_1001, 8'd1);
    we_cnt = 0; done_cnt = 0; done_cyc = 0; fld_rd = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      observe(cyc);
    end
    @(negedge clk);
    chk("mid_we_before", bus.mem_we, 1);
    chk("mid_we_cnt", we_cnt, 2);
    rst = 1'b0;
    #1;
    chk("mid_mem_we", bus.mem_we, 0);
    chk("mid_mem_addr", bus.mem_addr, 0);
    chk("mid_mem_wdata", bus.mem_wdata, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_game_over", game_over, 0);
    chk("mid_bad_piece", bad_piece, 0);
    chk("mid_cell0", cell_addr_0, 0);
    chk("mid_cell3", cell_addr_3, 0);
    chk("mid_piece_code", piece_code, 0);
    @(negedge clk);
    rst = 1'b1;
    clear_mem();
    load_piece(12'b0010_0100_1001, 8'd7);
    run_spawn(1'b0);
    chk("post_rst_done_cyc", done_cyc, 23);
    chk("post_rst_we_cnt", we_cnt, 4);
    chk("post_rst_wa3", wa[3], 34);
    chk("post_rst_wd0", wd[0], 7);

    // start re-pulsed in READ, CHECK and WRITE
    clear_mem();
    load_piece(12'b0110_1100_0000, 8'd2);
    run_spawn(1'b1);
    chk("rep_done_cnt", done_cnt, 1);
    chk("rep_done_cyc", done_cyc, 23);
    chk("rep_we_cnt", we_cnt, 4);
    chk("rep_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
